unary_decode: RTL and testbench
===============================

Name: unary_decode

Overview:
- Thermometer-to-binary decoder; the inverse of the binary-to-unary encoder in the same vlib.
- Takes a thermometer code of 2**(DOUT-1) bits on a valid/ready input and returns its binary value (number of set bits) on a valid/ready output.
- Processes CHUNK bits per cycle to keep the popcount adder narrow for wide codes.
- Sits downstream of unary-coded datapaths: arbiters, occupancy masks, level encoders.

Parameters:
- DOUT, 6, output width; input code width W = 2**(DOUT-1); value range 0..W fits DOUT bits.
- CHUNK, 8, bits consumed per COUNT cycle; power of two, 1 <= CHUNK <= W; NCH = W/CHUNK.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- din_ready  output  1  input handshake ready.
- din_valid  input  1  input handshake valid.
- din_data  input  W  thermometer code; bit i set means value > i.
- dout_ready  input  1  output handshake ready.
- dout_valid  output  1  output handshake valid.
- dout_data  output  DOUT  decoded binary value.
- dout_err  output  1  malformed-code flag, qualified by dout_valid (see Optional Feature).

Interface: one clock (clk); reset rst is asynchronous and active-high.

Behaviour:
- Handshakes: transfer occurs on a rising edge with valid&ready both high. din_ready and dout_valid never depend combinationally on din_valid/dout_ready.
- State machine: IDLE, COUNT, DONE.
- Reset (async, immediate):
  - State IDLE; shift register, accumulator and chunk index cleared.
  - dout_valid=0, dout_data=0, dout_err=0.
  - din_ready=0 while rst is high.
- IDLE:
  - din_ready=1 (when rst low).
  - On input transfer: capture din_data into the shift register, clear acc and index, go to COUNT.
- COUNT:
  - din_ready=0.
  - Each edge: acc += popcount(sreg[CHUNK-1:0]); sreg >>= CHUNK; idx++.
  - After edge with idx==NCH-1, go to DONE.
  - Exactly NCH edges are spent in COUNT.
- DONE:
  - dout_valid=1; dout_data=acc, dout_err=err, both stable until transfer.
  - On output transfer: go to IDLE, dout_valid drops next cycle.
  - dout_ready low holds DONE indefinitely.
- Latency: dout_valid rises on the NCH-th edge after the input-transfer edge (defaults: 4 edges).
- Throughput: one transaction per NCH+2 cycles minimum (defaults: 6). No overlap of input and output.
- Width rules: acc is DOUT bits. Maximum sum W = 2**(DOUT-1) fits, so no overflow. Per-chunk popcount width is clog2(CHUNK+1).
- dout_data = popcount(din_data) for any input, including malformed codes.
- CHUNK==W: NCH=1, single COUNT cycle.
- Reset mid-COUNT or mid-DONE: transaction discarded, no output produced, returns to IDLE.
- din_data changes after capture have no effect.

Optional Feature:
- Macro: UNARY_DECODE_CHECK_EN.
- Defined:
  - A sticky seen_zero flag is cleared on capture and carried across chunks.
  - err is set if any bit is 1 at a higher index than any 0 bit, within a chunk or against an earlier chunk's 0.
  - dout_err = err in DONE.
  - Legal codes are exactly the form 0..01..1, including all-zero and all-one.
- Not defined: no check logic; dout_err tied to 0; value output unchanged.

Test Plan:
- Reset then idle: hold rst 3 cycles -> dout_valid=0, dout_data=0, din_ready=0 during rst, 1 after release.
- Defaults, din_data=32'h0000_07FF, dout_ready=1 -> dout_valid rises 4 edges after accept, dout_data=11, dout_err=0, din_ready low until back in IDLE.
- Bounds: din_data=0 -> 0; din_data=32'hFFFF_FFFF -> 32 (6'b100000), no overflow.
- Backpressure: din_data=32'h0000_00FF, dout_ready=0 for 10 cycles -> dout_valid and dout_data=8 held stable, din_ready=0 throughout; a single transfer when dout_ready rises.
- With UNARY_DECODE_CHECK_EN: din_data=32'h0001_00FF -> dout_data=9, dout_err=1. din_data=32'h0000_FFFF -> 16, err=0. Without the macro: err=0 for both.
- Reset mid-COUNT: assert rst 2 edges after accept -> no dout_valid. A following input 32'h7 yields 3 with correct latency.

Source files
------------

// File: rtl/unary_decode.sv
// Thermometer-to-binary decoder: counts set bits of a 2**(DOUT-1)-bit code, CHUNK bits per cycle.
// Define UNARY_DECODE_CHECK_EN to flag malformed (non 0..01..1) codes on dout_err.
module unary_decode #(
  parameter int DOUT  = 6,
  parameter int CHUNK = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    din_ready,
  input  logic                    din_valid,
  input  logic [2**(DOUT-1)-1:0]  din_data,
  input  logic                    dout_ready,
  output logic                    dout_valid,
  output logic [DOUT-1:0]         dout_data,
  output logic                    dout_err
);

  localparam int W    = 2**(DOUT-1);
  localparam int NCH  = W / CHUNK;
  localparam int PCW  = $clog2(CHUNK + 1);
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t          state;
  logic [W-1:0]    sreg;
  logic [DOUT-1:0] acc;
  logic [IDXW-1:0] idx;
  logic            din_fire;
  logic [PCW-1:0]  chunk_cnt;

  function automatic logic [PCW-1:0] popcount(input logic [CHUNK-1:0] v);
    logic [PCW-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK; i++) c = c + PCW'(v[i]);
    return c;
  endfunction

  // Ready only depends on state, so it never waits on din_valid.
  assign din_ready = (state == IDLE) && !rst;
  assign din_fire  = din_valid && din_ready;
  assign chunk_cnt = popcount(sreg[CHUNK-1:0]);
  assign dout_data = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      acc        <= '0;
      idx        <= '0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (din_fire) begin
            sreg  <= din_data;
            acc   <= '0;
            idx   <= '0;
            state <= COUNT;
          end
        end
        COUNT: begin
          acc  <= acc + DOUT'(chunk_cnt);
          sreg <= sreg >> CHUNK;
          idx  <= idx + IDXW'(1);
          if (idx == IDXW'(NCH - 1)) begin
            state      <= DONE;
            dout_valid <= 1'b1;
          end
        end
        DONE: begin
          if (dout_ready) begin
            state      <= IDLE;
            dout_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef UNARY_DECODE_CHECK_EN
  logic seen_zero;
  logic err;
  logic chunk_bad;
  logic chunk_seen;

  // A 1 anywhere above a 0 (this chunk or an earlier one) breaks the 0..01..1 form.
  always_comb begin
    chunk_bad  = 1'b0;
    chunk_seen = seen_zero;
    for (int i = 0; i < CHUNK; i++) begin
      if (sreg[i] && chunk_seen) chunk_bad = 1'b1;
      if (!sreg[i]) chunk_seen = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_zero <= 1'b0;
      err       <= 1'b0;
    end else if (state == IDLE) begin
      if (din_fire) begin
        seen_zero <= 1'b0;
        err       <= 1'b0;
      end
    end else if (state == COUNT) begin
      seen_zero <= chunk_seen;
      err       <= err | chunk_bad;
    end
  end

  assign dout_err = err;
`else
  assign dout_err = 1'b0;
`endif

endmodule

// File: tb/tb_unary_decode.sv
// Directed self-checking bench for unary_decode at default parameters (DOUT=6, CHUNK=8).
module tb_unary_decode;

  logic        clk;
  logic        rst;
  logic        din_ready;
  logic        din_valid;
  logic [31:0] din_data;
  logic        dout_ready;
  logic        dout_valid;
  logic [5:0]  dout_data;
  logic        dout_err;

  int checks = 0;
  int errors = 0;

`ifdef UNARY_DECODE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  unary_decode dut (
    .clk        (clk),
    .rst        (rst),
    .din_ready  (din_ready),
    .din_valid  (din_valid),
    .din_data   (din_data),
    .dout_ready (dout_ready),
    .dout_valid (dout_valid),
    .dout_data  (dout_data),
    .dout_err   (dout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; hold > 0 keeps dout_ready low for that many cycles in DONE.
  task automatic applyStimulus(input logic [31:0] data, input logic [5:0] exp_val,
                               input logic exp_err, input int hold);
    int lat;
    lat = 0;
    while (!din_ready && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("din_ready_idle", {31'd0, din_ready}, 32'd1);
    din_valid  = 1'b1;
    din_data   = data;
    dout_ready = (hold == 0);
    tick();
    din_valid = 1'b0;
    din_data  = ~data;
    lat = 0;
    while (!dout_valid && lat < 20) begin
      checkOutput("din_ready_busy", {31'd0, din_ready}, 32'd0);
      tick();
      lat++;
    end
    checkOutput("latency", lat, 32'd4);
    checkOutput("dout_data", {26'd0, dout_data}, {26'd0, exp_val});
    checkOutput("dout_err", {31'd0, dout_err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("hold_valid", {31'd0, dout_valid}, 32'd1);
      checkOutput("hold_data", {26'd0, dout_data}, {26'd0, exp_val});
      checkOutput("hold_ready", {31'd0, din_ready}, 32'd0);
    end
    dout_ready = 1'b1;
    tick();
    checkOutput("valid_drop", {31'd0, dout_valid}, 32'd0);
    checkOutput("back_idle", {31'd0, din_ready}, 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    din_valid  = 1'b0;
    din_data   = '0;
    dout_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_valid", {31'd0, dout_valid}, 32'd0);
      checkOutput("rst_data", {26'd0, dout_data}, 32'd0);
      checkOutput("rst_ready", {31'd0, din_ready}, 32'd0);
    end
    rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", {31'd0, din_ready}, 32'd1);
    tick();

    $display("[TB] basic and boundary codes");
    applyStimulus(32'h0000_07FF, 6'd11, 1'b0, 0);
    applyStimulus(32'h0000_0000, 6'd0,  1'b0, 0);
    applyStimulus(32'hFFFF_FFFF, 6'd32, 1'b0, 0);
    applyStimulus(32'h0000_FFFF, 6'd16, 1'b0, 0);

    $display("[TB] backpressure");
    applyStimulus(32'h0000_00FF, 6'd8, 1'b0, 10);

    $display("[TB] malformed codes");
    applyStimulus(32'h0001_00FF, 6'd9, CHK, 0);
    applyStimulus(32'h0000_0005, 6'd2, CHK, 0);
    applyStimulus(32'h0000_0100, 6'd1, CHK, 0);

    $display("[TB] reset during COUNT");
    din_valid = 1'b1;
    din_data  = 32'h0000_03FF;
    tick();
    din_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst_ready", {31'd0, din_ready}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("midrst_novalid", {31'd0, dout_valid}, 32'd0);
    end
    applyStimulus(32'h0000_0007, 6'd3, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
